// File: rtl/and32_unit_pkg.sv
// Shared ALU definitions used by the AND leg of the MIPS ALU datapath.
// Holds the default datapath width, the ALU opcodes and an all-ones mask helper.
package and32_unit_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int MAX_MASK_WIDTH = 64;

  typedef enum logic [3:0] {
    ALU_OP_AND = 4'b0000,
    ALU_OP_OR  = 4'b0001,
    ALU_OP_ADD = 4'b0010,
    ALU_OP_SUB = 4'b0110,
    ALU_OP_SLT = 4'b0111
  } alu_op_e;

  localparam alu_op_e AND_OPCODE = ALU_OP_AND;

  // Low w bits set; callers take the slice they need (w <= MAX_MASK_WIDTH).
  function automatic logic [MAX_MASK_WIDTH-1:0] all_ones_mask(input int w);
    logic [MAX_MASK_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_MASK_WIDTH; i++) begin
      if (i < w) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/and32_unit_cell.sv
// One-bit AND cell; replicated across the operand width by and32_unit.
module and_bit_cell (
  input  logic x,
  input  logic y,
  output logic z
);

  assign z = x & y;

endmodule

// File: rtl/and32_unit.sv
// Bitwise AND unit: combinational result for the ALU mux plus a registered,
// valid-qualified copy with zero / all-ones flags for pipeline staging.
module and32_unit
  import and32_unit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] res_comb,
  output logic [WIDTH-1:0] res,
  output logic             out_valid,
  output logic             zero,
  output logic             ones
);

  localparam logic [MAX_MASK_WIDTH-1:0] ONES_FULL = all_ones_mask(WIDTH);
  localparam logic [WIDTH-1:0]          ONES_MASK = ONES_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] res_d, res_q;
  logic             valid_d, valid_q;
  logic             zero_d, zero_q;
  logic             ones_d, ones_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    and_bit_cell u_cell (
      .x (a[i]),
      .y (b[i]),
      .z (res_comb[i])
    );
  end

  // Idle cycles hold the last result so unknown operands never reach the flops.
  always_comb begin
    res_d   = res_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    valid_d = 1'b0;
    if (in_valid) begin
      res_d   = res_comb;
      zero_d  = (res_comb == '0);
      ones_d  = (res_comb == ONES_MASK);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      ones_q  <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      ones_q  <= ones_d;
    end
  end

  assign res       = res_q;
  assign out_valid = valid_q;
  assign zero      = zero_q;
  assign ones      = ones_q;

endmodule

// File: tb/tb_and32_unit.sv
// Self-checking bench for and32_unit: vector table plus scoreboard queue,
// with hand-written hold and mid-operation reset sequences.
module tb_and32_unit;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        v;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ones;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ones;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_valid = 1'b0;
  logic [31:0] res_comb;
  logic [31:0] res;
  logic        out_valid;
  logic        zero;
  logic        ones;

  int   vectors_applied = 0;
  int   miscompares = 0;
  exp_t sb_q[$];
  exp_t hold;
  vec_t vecs[6];

  and32_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .res_comb  (res_comb),
    .res       (res),
    .out_valid (out_valid),
    .zero      (zero),
    .ones      (ones)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational path, queue the expected capture.
  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic v,
                               input logic [31:0] er, input logic ez, input logic eo);
    exp_t e;
    a = va;
    b = vb;
    in_valid = v;
    #1;
    check("res_comb", res_comb, va & vb);
    if (v) begin
      e.res  = er;
      e.zero = ez;
      e.ones = eo;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Compare registered outputs against the scoreboard (capture) or the held value (idle).
  task automatic checkOutput(input logic v);
    if (v) begin
      if (sb_q.size() == 0) begin
        vectors_applied++;
        miscompares++;
        $display("[TB] FAIL scoreboard: empty queue on capture at %0t", $time);
      end else begin
        hold = sb_q.pop_front();
      end
    end
    check("out_valid", {31'b0, out_valid}, {31'b0, v});
    check("res", res, hold.res);
    check("zero", {31'b0, zero}, {31'b0, hold.zero});
    check("ones", {31'b0, ones}, {31'b0, hold.ones});
  endtask

  task automatic checkReset();
    check("rst res", res, 32'h0);
    check("rst out_valid", {31'b0, out_valid}, 32'h0);
    check("rst zero", {31'b0, zero}, 32'h0);
    check("rst ones", {31'b0, ones}, 32'h0);
  endtask

  task automatic runCycle(input logic [31:0] va, input logic [31:0] vb, input logic v);
    logic [31:0] r;
    r = va & vb;
    applyStimulus(va, vb, v, r, (r == 32'h0), (r == 32'hFFFFFFFF));
    checkOutput(v);
  endtask

  initial begin
    vecs[0] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[2] = '{32'h0003FFFF, 32'hFFFFFFFF, 1'b1, 32'h0003FFFF, 1'b0, 1'b0};
    vecs[3] = '{32'h0003FFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[4] = '{32'h12345678, 32'hF0F0F0F0, 1'b1, 32'h10305070, 1'b0, 1'b0};
    vecs[5] = '{32'h80000001, 32'hFFFFFFFF, 1'b1, 32'h80000001, 1'b0, 1'b0};
    hold = '{res: 32'h0, zero: 1'b0, ones: 1'b0};

    // Asynchronous reset with arbitrary operands, before any clock edge.
    a = 32'hDEADBEEF;
    b = 32'h0FF00FF0;
    #2 rst_n = 1'b0;
    #1;
    checkReset();
    check("rst res_comb", res_comb, 32'h0EA00EE0);
    #4 rst_n = 1'b1;

    // Table: back-to-back captures, one result per cycle.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].v, vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_ones);
      checkOutput(vecs[i].v);
    end

    // Idle cycles with changing operands: registered outputs hold.
    for (int i = 0; i < 3; i++) begin
      runCycle($urandom, $urandom, 1'b0);
    end

    // A few random captures interleaved with idles.
    for (int i = 0; i < 6; i++) begin
      runCycle($urandom, $urandom, i[0]);
    end

    // Mid-operation reset between two accepted captures.
    runCycle(32'hFFFF0000, 32'h0F0F0F0F, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkReset();
    hold = '{res: 32'h0, zero: 1'b0, ones: 1'b0};
    sb_q.delete();
    #1 rst_n = 1'b1;
    applyStimulus(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b1, 32'h05050505, 1'b0, 1'b0);
    checkOutput(1'b1);
    runCycle(32'h12121212, 32'h34343434, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/and32_unit.md
Name: and32_unit

Overview:
- Bitwise 32-bit AND unit, the logic-AND leg of the MIPS ALU datapath.
- Exposes two results:
  - a purely combinational result for the ALU result mux;
  - a registered, valid-qualified copy with zero / all-ones status flags, for pipeline staging and flag generation.
- Built structurally from one-bit AND cells.

Parameters:
- WIDTH, 32: operand and result width in bits; must be ≥ 1.

Ports:
- clk, input, 1: single system clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- in_valid, input, 1: a/b are valid this cycle; capture them.
- res_comb, output, WIDTH: combinational a & b, same cycle, no reset dependence.
- res, output, WIDTH: registered a & b.
- out_valid, output, 1: res, zero and ones hold a result captured on the previous accepted cycle.
- zero, output, 1: registered flag, res == 0.
- ones, output, 1: registered flag, res == all ones.

Behaviour:
- Combinational path:
  - res_comb[i] = a[i] & b[i] for every bit i.
  - Zero-delay path from a/b; no clock or reset involvement.
- Reset: while rst_n is low, asynchronously force res = 0, out_valid = 0, zero = 0, ones = 0. Flags are cleared, not derived, during reset.
- Accepted cycle: on a rising clk edge with rst_n high and in_valid = 1:
  - res <= a & b;
  - zero <= ((a & b) == 0);
  - ones <= ((a & b) == all ones);
  - out_valid <= 1.
- Latency: 1 cycle from the in_valid edge to res/flags/out_valid.
- Hold cycle: on a rising edge with in_valid = 0:
  - res, zero and ones hold their previous values;
  - out_valid <= 0.
- Back-to-back in_valid every cycle: full throughput, one result per cycle, no bubbles.
- No backpressure: out_valid is a one-cycle pulse per accepted input.
- Reset mid-operation: asserting rst_n low clears everything immediately regardless of clk.
  - On deassertion, the first capture happens at the first rising edge with in_valid = 1.
  - A capture on the same edge as deassertion is permitted (synchronize deassertion upstream).
- Flag interaction when WIDTH = 1: zero and ones are mutually exclusive and exactly one is set after each capture.
- X on a/b while in_valid = 0 must not disturb the registered outputs.
- No arithmetic: no carries, no width extension; output width equals input width.

Decomposition:
- Shared ALU package holds:
  - WIDTH default (32);
  - the ALU opcode constant selecting AND;
  - an all-ones constant helper.
- Sub-module and_bit_cell (inputs x, y; output z = x & y).
  - Instantiated WIDTH times via generate to form res_comb.
- Registers and flag logic live in the top module, reading res_comb.

Test Plan:
1. rst_n = 0 with arbitrary a/b → res = 0, out_valid = 0, zero = 0, ones = 0 immediately, without a clk edge. res_comb still equals a & b.
2. a = 32'h00000000, b = 32'hFFFFFFFF, in_valid = 1 → res_comb = 0 same cycle. Next edge: res = 32'h00000000, zero = 1, ones = 0, out_valid = 1.
3. a = 32'hFFFFFFFF, b = 32'hFFFFFFFF, in_valid = 1 → next edge: res = 32'hFFFFFFFF, zero = 0, ones = 1.
4. Back-to-back inputs:
   - a = 32'h0003FFFF, b = 32'hFFFFFFFF, then a = 32'h0003FFFF, b = 32'h00000000, on consecutive cycles;
   - response: res = 32'h0003FFFF with zero = 0 and ones = 0, then res = 32'h00000000 with zero = 1;
   - out_valid stays high for both cycles.
5. in_valid = 0 for 3 cycles while a/b change randomly → res and flags hold the last captured value, out_valid = 0, res_comb tracks a & b each cycle.
6. Assert rst_n low between two accepted captures (mid-cycle, async) → outputs clear at once. After release, the next in_valid with a = 32'hA5A5A5A5, b = 32'h0F0F0F0F yields res = 32'h05050505 one cycle later.
